// File: rtl/paddle_motion.sv
// paddle_motion: per-frame paddle position integrator.
//
// Samples the move/up command on each frame_tick and steps the registered paddle
// position. Sustained motion in one direction ramps the step size by one pixel every
// ACCEL_FRAMES frames, up to MAX_SPEED. The position is clamped to [0, LIMIT], where
// LIMIT = SCREEN_H - PADDLE_H. A center pulse overrides any frame_tick in the same
// cycle and returns the paddle to LIMIT/2 at rest.
//
// Ports:
//   clock       in   system clock
//   reset_n     in   asynchronous active-low reset
//   frame_tick  in   one-cycle pulse per video frame
//   move        in   request motion this frame (sampled on frame_tick only)
//   up          in   direction: 1 = increasing y, 0 = decreasing y
//   center      in   one-cycle recenter request (wins over frame_tick)
//   paddle_y    out  top edge of the paddle, registered
//   speed       out  current step size, 0 when idle
//   at_top      out  registered, paddle_y == 0
//   at_bottom   out  registered, paddle_y == LIMIT
module paddle_motion #(
  parameter int unsigned PADDLE_H     = 48,
  parameter int unsigned SCREEN_H     = 480,
  parameter int unsigned MAX_SPEED    = 8,
  parameter int unsigned ACCEL_FRAMES = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       move,
  input  logic       up,
  input  logic       center,
  output logic [9:0] paddle_y,
  output logic [3:0] speed,
  output logic       at_top,
  output logic       at_bottom
);

  localparam logic [9:0] Limit    = 10'(SCREEN_H - PADDLE_H);
  localparam logic [9:0] CenterY  = 10'((SCREEN_H - PADDLE_H) / 2);
  localparam logic [3:0] MaxSpeed = 4'(MAX_SPEED);
  localparam int unsigned CntW    = $clog2(ACCEL_FRAMES);
  localparam logic [CntW-1:0] CntLast = CntW'(ACCEL_FRAMES - 1);

  typedef enum logic [1:0] {StIdle, StInc, StDec} state_e;

  state_e          state_q, state_d;
  logic [9:0]      y_q, y_d;
  logic [3:0]      speed_q, speed_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            at_top_q, at_bottom_q;

  state_e      req_state;
  logic [3:0]  step;
  logic [10:0] y_sum;

  assign req_state = up ? StInc : StDec;
  assign y_sum     = {1'b0, y_q} + {7'b0, step};

  always_comb begin
    state_d = state_q;
    speed_d = speed_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    step    = 4'd0;

    if (center) begin
      state_d = StIdle;
      speed_d = 4'd0;
      cnt_d   = '0;
      y_d     = CenterY;
    end else if (frame_tick) begin
      if (!move) begin
        state_d = StIdle;
        speed_d = 4'd0;
        cnt_d   = '0;
      end else begin
        if (state_q != req_state) begin
          // New motion or reversal restarts the ramp at one pixel.
          state_d = req_state;
          speed_d = 4'd1;
          cnt_d   = CntW'(1);
          step    = 4'd1;
        end else begin
          // Step uses the pre-increment speed.
          step = speed_q;
          if (cnt_q == CntLast) begin
            cnt_d = '0;
            if (speed_q < MaxSpeed) begin
              speed_d = speed_q + 4'd1;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end

        if (up) begin
          y_d = (y_sum > {1'b0, Limit}) ? Limit : y_sum[9:0];
        end else begin
          y_d = (y_q < {6'b0, step}) ? 10'd0 : y_q - {6'b0, step};
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      y_q         <= CenterY;
      speed_q     <= 4'd0;
      cnt_q       <= '0;
      at_top_q    <= 1'b0;
      at_bottom_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      y_q         <= y_d;
      speed_q     <= speed_d;
      cnt_q       <= cnt_d;
      // Flags track the next-state position so they align with paddle_y.
      at_top_q    <= (y_d == 10'd0);
      at_bottom_q <= (y_d == Limit);
    end
  end

  assign paddle_y  = y_q;
  assign speed     = speed_q;
  assign at_top    = at_top_q;
  assign at_bottom = at_bottom_q;

endmodule
